qint: RTL and testbench

QINT -- requirements
Module: qint

---
 rtl/qint.sv | 164 ++++++++++++++++
 tb/tb_qint.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/qint.sv
// QBUS interrupt requester: level-encoded BIRQ drive, DIN/IAK arbitration, vector cycle.
// Define QINT_SYNC_EN to pass RDIN, RIAKI and RIRQ through two-flop synchronizers.
module qint (
    input  logic       qclk,
    input  logic       RINIT,
    input  logic [4:7] intp,
    input  logic       RDIN,
    input  logic [4:7] RIRQ,
    input  logic       RIAKI,
    output logic [4:7] TIRQ,
    output logic       TIAKO,
    input  logic       interrupt_request,
    output logic       assert_vector
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        VECTOR  = 2'd2
    } state_t;

    state_t     state;
    logic       pend;
    logic       din_seen;
    logic       elig;
    logic       rdin;
    logic       riaki;
    logic [4:7] rirq;
    logic [1:0] lvl;
    logic [4:7] pat;
    logic       elig_calc;
    logic       elig_eff;

`ifdef QINT_SYNC_EN
    logic [1:0] din_s;
    logic [1:0] iak_s;
    logic [4:7] irq_s1;
    logic [4:7] irq_s2;

    always_ff @(posedge qclk) begin
        if (RINIT) begin
            din_s  <= '0;
            iak_s  <= '0;
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            din_s  <= {din_s[0], RDIN};
            iak_s  <= {iak_s[0], RIAKI};
            irq_s1 <= RIRQ;
            irq_s2 <= irq_s1;
        end
    end

    assign rdin  = din_s[1];
    assign riaki = iak_s[1];
    assign rirq  = irq_s2;
`else
    assign rdin  = RDIN;
    assign riaki = RIAKI;
    assign rirq  = RIRQ;
`endif

    // Highest selected level wins; no selection falls back to level 4.
    always_comb begin
        lvl = 2'd0;
        if (intp[7])      lvl = 2'd3;
        else if (intp[6]) lvl = 2'd2;
        else if (intp[5]) lvl = 2'd1;
    end

    always_comb begin
        pat       = 4'b1000;
        elig_calc = 1'b1;
        case (lvl)
            2'd0: begin
                pat       = 4'b1000;
                elig_calc = ~|rirq[5:7];
            end
            2'd1: begin
                pat       = 4'b1100;
                elig_calc = ~|rirq[6:7];
            end
            2'd2: begin
                pat       = 4'b1010;
                elig_calc = ~rirq[7];
            end
            default: begin
                pat       = 4'b1011;
                elig_calc = 1'b1;
            end
        endcase
    end

    // Eligibility is frozen on the first DIN sample; before that use the live value.
    assign elig_eff = rdin & (din_seen ? elig : elig_calc);

    always_ff @(posedge qclk) begin
        if (RINIT) begin
            state         <= IDLE;
            pend          <= 1'b0;
            din_seen      <= 1'b0;
            elig          <= 1'b0;
            TIRQ          <= '0;
            TIAKO         <= 1'b0;
            assert_vector <= 1'b0;
        end else begin
            if (!rdin) begin
                din_seen <= 1'b0;
                elig     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    TIAKO         <= riaki;
                    TIRQ          <= '0;
                    assert_vector <= 1'b0;
                    if (interrupt_request) begin
                        state <= REQUEST;
                        TIRQ  <= pat;
                    end
                end
                REQUEST: begin
                    TIRQ <= pat;
                    if (rdin && !din_seen) begin
                        din_seen <= 1'b1;
                        elig     <= elig_calc;
                    end
                    if (riaki && elig_eff) begin
                        state         <= VECTOR;
                        TIRQ          <= '0;
                        TIAKO         <= 1'b0;
                        assert_vector <= 1'b1;
                        pend          <= 1'b0;
                    end else begin
                        TIAKO <= riaki;
                    end
                end
                VECTOR: begin
                    TIAKO    <= 1'b0;
                    TIRQ     <= '0;
                    din_seen <= 1'b0;
                    elig     <= 1'b0;
                    pend     <= pend | interrupt_request;
                    if (!rdin || !riaki) begin
                        assert_vector <= 1'b0;
                        pend          <= 1'b0;
                        if (pend || interrupt_request) begin
                            state <= REQUEST;
                            TIRQ  <= pat;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    TIRQ          <= '0;
                    TIAKO         <= 1'b0;
                    assert_vector <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qint.sv
// Directed bench for qint: reset, arbitration, grant pass-through, re-request, abort.
module tb_qint;

    logic       qclk = 1'b0;
    logic       RINIT;
    logic [4:7] intp;
    logic       RDIN;
    logic [4:7] RIRQ;
    logic       RIAKI;
    logic [4:7] TIRQ;
    logic       TIAKO;
    logic       interrupt_request;
    logic       assert_vector;

    int checks = 0;
    int errors = 0;

    qint dut (
        .qclk              (qclk),
        .RINIT             (RINIT),
        .intp              (intp),
        .RDIN              (RDIN),
        .RIRQ              (RIRQ),
        .RIAKI             (RIAKI),
        .TIRQ              (TIRQ),
        .TIAKO             (TIAKO),
        .interrupt_request (interrupt_request),
        .assert_vector     (assert_vector)
    );

    always #5 qclk = ~qclk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge qclk);
        #1;
    endtask

    initial begin
        RINIT = 1'b1;
        intp = 4'b1000;
        RDIN = 1'b0;
        RIRQ = 4'b0000;
        RIAKI = 1'b0;
        interrupt_request = 1'b0;
        tick();
        tick();
        chk("rst_tirq", {4'b0, TIRQ}, 8'h00);
        chk("rst_tiako", {7'b0, TIAKO}, 8'h00);
        chk("rst_av", {7'b0, assert_vector}, 8'h00);
        RINIT = 1'b0;
        tick();

        // L4 eligible vector cycle
        interrupt_request = 1'b1;
        chk("l4_pre_tirq", {4'b0, TIRQ}, 8'h00);
        tick();
        interrupt_request = 1'b0;
        chk("l4_tirq", {4'b0, TIRQ}, 8'h08);
        RDIN = 1'b1;
        tick();
        chk("l4_din_av", {7'b0, assert_vector}, 8'h00);
        RIAKI = 1'b1;
        tick();
        chk("l4_vec_av", {7'b0, assert_vector}, 8'h01);
        chk("l4_vec_tirq", {4'b0, TIRQ}, 8'h00);
        chk("l4_vec_tiako", {7'b0, TIAKO}, 8'h00);
        RDIN = 1'b0;
        RIAKI = 1'b0;
        tick();
        chk("l4_end_av", {7'b0, assert_vector}, 8'h00);
        tick();
        chk("l4_idle_tirq", {4'b0, TIRQ}, 8'h00);

        // L4 blocked by a level-6 requester
        interrupt_request = 1'b1;
        tick();
        interrupt_request = 1'b0;
        RIRQ = 4'b1010;
        RDIN = 1'b1;
        tick();
        RIAKI = 1'b1;
        tick();
        chk("blk_tiako", {7'b0, TIAKO}, 8'h01);
        chk("blk_av", {7'b0, assert_vector}, 8'h00);
        chk("blk_tirq", {4'b0, TIRQ}, 8'h08);
        RIAKI = 1'b0;
        tick();
        chk("blk_tiako_drop", {7'b0, TIAKO}, 8'h00);
        RDIN = 1'b0;
        RIRQ = 4'b0000;
        tick();
        RDIN = 1'b1;
        RIRQ = 4'b1000;
        tick();
        RIAKI = 1'b1;
        tick();
        chk("retry_av", {7'b0, assert_vector}, 8'h01);
        RDIN = 1'b0;
        RIAKI = 1'b0;
        RIRQ = 4'b0000;
        tick();
        chk("retry_end_av", {7'b0, assert_vector}, 8'h00);

        // L7 with full bus, new strobe during vector
        intp = 4'b0001;
        interrupt_request = 1'b1;
        tick();
        interrupt_request = 1'b0;
        chk("l7_tirq", {4'b0, TIRQ}, 8'h0b);
        RIRQ = 4'b1111;
        RDIN = 1'b1;
        tick();
        RIAKI = 1'b1;
        tick();
        chk("l7_av", {7'b0, assert_vector}, 8'h01);
        interrupt_request = 1'b1;
        tick();
        interrupt_request = 1'b0;
        chk("l7_vec_hold", {7'b0, assert_vector}, 8'h01);
        RDIN = 1'b0;
        RIAKI = 1'b0;
        tick();
        chk("rereq_av", {7'b0, assert_vector}, 8'h00);
        chk("rereq_tirq", {4'b0, TIRQ}, 8'h0b);

        // Reset aborts a vector cycle
        RDIN = 1'b1;
        RIRQ = 4'b1011;
        tick();
        RIAKI = 1'b1;
        tick();
        chk("abort_pre_av", {7'b0, assert_vector}, 8'h01);
        RINIT = 1'b1;
        tick();
        chk("abort_av", {7'b0, assert_vector}, 8'h00);
        chk("abort_tirq", {4'b0, TIRQ}, 8'h00);
        chk("abort_tiako", {7'b0, TIAKO}, 8'h00);
        RINIT = 1'b0;
        RDIN = 1'b0;
        RIAKI = 1'b0;
        RIRQ = 4'b0000;
        tick();
        chk("abort_idle_tirq", {4'b0, TIRQ}, 8'h00);

        // Idle grant pass-through
        intp = 4'b1000;
        RIAKI = 1'b1;
        chk("pass_pre", {7'b0, TIAKO}, 8'h00);
        tick();
        chk("pass_hi", {7'b0, TIAKO}, 8'h01);
        RIAKI = 1'b0;
        tick();
        chk("pass_lo", {7'b0, TIAKO}, 8'h00);

        // Level patterns L5, L6, then reset overriding a strobe
        intp = 4'b0100;
        interrupt_request = 1'b1;
        tick();
        interrupt_request = 1'b0;
        chk("l5_tirq", {4'b0, TIRQ}, 8'h0c);
        intp = 4'b0010;
        tick();
        chk("l6_tirq", {4'b0, TIRQ}, 8'h0a);
        RINIT = 1'b1;
        interrupt_request = 1'b1;
        tick();
        RINIT = 1'b0;
        interrupt_request = 1'b0;
        chk("ovr_tirq", {4'b0, TIRQ}, 8'h00);
        tick();
        chk("ovr_idle_tirq", {4'b0, TIRQ}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
